// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared opcodes, sequencer state encoding and instruction-word helper
// for the fetch controller and its bench.
package instr_fetch_ctrl_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_OUT = 8'h03;
    localparam logic [7:0] OP_JMP = 8'h04;
    localparam logic [7:0] OP_HLT = 8'hff;

    typedef enum logic [1:0] {
        IFC_IDLE,
        IFC_CPURST,
        IFC_RUN,
        IFC_HALTED
    } ifc_state_e;

    function automatic logic [31:0] op_word(input logic [7:0] op);
        return {op, 24'h0};
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl_prog_mem.sv
// Program memory: synchronous write, asynchronous read, no reset.
module prog_mem #(
    parameter int DEPTH = 256,
    parameter int IW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [IW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: loads program memory while the core is parked, then
// runs it until HLT, stop, out-of-range PC or cycle-budget exhaustion.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic [CNT_W-1:0]  max_cycles,
    input  logic [31:0]       pc_in,
    output logic [31:0]       instruction,
    output logic              cpu_reset_n,
    output logic              running,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              err_pc,
    output logic              err_load,
    output logic              timeout
);

    localparam int          IW    = $clog2(IMEM_DEPTH);
    localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);

    ifc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_pc_q, err_pc_d;
    logic             err_load_q, err_load_d;
    logic             timeout_q, timeout_d;

    logic        we;
    logic [31:0] rdata;
    logic        pc_oob, addr_oob, budget_hit;

    prog_mem #(
        .DEPTH (IMEM_DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (load_addr[IW-1:0]),
        .wdata (load_data),
        .raddr (pc_in[IW-1:0]),
        .rdata (rdata)
    );

    assign pc_oob     = pc_in >= DEPTH;
    assign addr_oob   = 32'(load_addr) >= DEPTH;
    assign cnt_inc    = cnt_q + 1'b1;
    // cnt_inc wraps to zero at saturation, so a nonzero budget never matches there
    assign budget_hit = (max_cycles != '0) && (cnt_inc == max_cycles);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_pc_d    = err_pc_q;
        err_load_d  = err_load_q;
        timeout_d   = timeout_q;
        we          = 1'b0;
        load_ready  = 1'b0;
        cpu_reset_n = 1'b0;
        instruction = op_word(OP_NOP);
        unique case (state_q)
            IFC_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    if (addr_oob) err_load_d = 1'b1;
                    else          we = 1'b1;
                end
                if (start) state_d = IFC_CPURST;
            end
            IFC_CPURST: begin
                cnt_d     = '0;
                err_pc_d  = 1'b0;
                timeout_d = 1'b0;
                state_d   = IFC_RUN;
            end
            IFC_RUN: begin
                cpu_reset_n = 1'b1;
                instruction = pc_oob ? op_word(OP_HLT) : rdata;
                if (cnt_q != '1) cnt_d = cnt_inc;
                if (pc_oob) begin
                    err_pc_d = 1'b1;
                    state_d  = IFC_HALTED;
                end else if (rdata[31:24] == OP_HLT) begin
                    state_d = IFC_HALTED;
                end else if (stop) begin
                    state_d = IFC_HALTED;
                end else if (budget_hit) begin
                    timeout_d = 1'b1;
                    state_d   = IFC_HALTED;
                end
            end
            IFC_HALTED: begin
                cpu_reset_n = 1'b1;
                instruction = op_word(OP_HLT);
                if (start)      state_d = IFC_CPURST;
                else if (clear) state_d = IFC_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IFC_IDLE;
            cnt_q      <= '0;
            err_pc_q   <= 1'b0;
            err_load_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_pc_q   <= err_pc_d;
            err_load_q <= err_load_d;
            timeout_q  <= timeout_d;
        end
    end

    assign running     = state_q == IFC_RUN;
    assign halted      = state_q == IFC_HALTED;
    assign cycle_count = cnt_q;
    assign err_pc      = err_pc_q;
    assign err_load    = err_load_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench: fetch controller driving a tiny behavioural core
// whose PC follows NOP/ALU (+1), JMP (target) and HLT (hold).
module tb_instr_fetch_ctrl;
    import instr_fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid, load_ready;
    logic [8:0]  load_addr;
    logic [31:0] load_data;
    logic        start, stop, clear;
    logic [15:0] max_cycles;
    logic [31:0] pc_in;
    logic [31:0] instruction;
    logic        cpu_reset_n, running, halted;
    logic [15:0] cycle_count;
    logic        err_pc, err_load, timeout;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] W_NOP  = {OP_NOP, 24'h0};
    localparam logic [31:0] W_HLT  = {OP_HLT, 24'h0};
    localparam logic [31:0] W_ADD  = {OP_ADD, 24'h000011};
    localparam logic [31:0] W_SUB  = {OP_SUB, 24'h000022};
    localparam logic [31:0] W_OUT  = {OP_OUT, 24'h000033};
    localparam logic [31:0] W_END  = {OP_HLT, 24'h000044};
    localparam logic [31:0] W_NEW  = {OP_HLT, 24'h00abcd};
    localparam logic [31:0] W_J0   = {OP_JMP, 24'd0};
    localparam logic [31:0] W_J300 = {OP_JMP, 24'd300};

    always #5 clk = ~clk;

    instr_fetch_ctrl #(
        .IMEM_DEPTH (256),
        .ADDR_W     (9),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .max_cycles  (max_cycles),
        .pc_in       (pc_in),
        .instruction (instruction),
        .cpu_reset_n (cpu_reset_n),
        .running     (running),
        .halted      (halted),
        .cycle_count (cycle_count),
        .err_pc      (err_pc),
        .err_load    (err_load),
        .timeout     (timeout)
    );

    logic [31:0] core_pc;
    assign pc_in = core_pc;

    always @(posedge clk) begin
        if (!cpu_reset_n) core_pc <= 32'h0;
        else if (instruction[31:24] == OP_HLT) core_pc <= core_pc;
        else if (instruction[31:24] == OP_JMP) core_pc <= {8'h0, instruction[23:0]};
        else core_pc <= core_pc + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic ld(input logic [8:0] a, input logic [31:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic go;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog [4];
        int n;
        prog[0] = W_ADD; prog[1] = W_SUB; prog[2] = W_OUT; prog[3] = W_END;
        reset = 1'b1;
        load_valid = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; stop = 1'b0; clear = 1'b0; max_cycles = '0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_run", running, 0);
        chk("rst_halt", halted, 0);
        chk("rst_cnt", cycle_count, 0);
        chk("rst_flags", {err_pc, err_load, timeout}, 0);
        chk("rst_ready", load_ready, 1);
        chk("rst_cpurst", cpu_reset_n, 0);
        chk("rst_instr", instruction, W_NOP);
        reset = 1'b1;
        @(negedge clk);

        // basic program
        for (int i = 0; i < 4; i++) ld(9'(i), prog[i]);
        go();
        chk("t1_cpurst_n", cpu_reset_n, 0);
        chk("t1_cpurst_run", running, 0);
        chk("t1_cpurst_instr", instruction, W_NOP);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_instr", instruction, prog[i]);
            chk("t1_pc", pc_in, 32'(i));
            chk("t1_run", {running, cpu_reset_n}, 2'b11);
        end
        @(negedge clk);
        chk("t1_halt", halted, 1);
        chk("t1_hpc", pc_in, 3);
        chk("t1_cnt", cycle_count, 4);
        chk("t1_hinstr", instruction, W_HLT);

        // load offered outside IDLE stalls until IDLE
        start = 1'b1;
        load_valid = 1'b1; load_addr = 9'd2; load_data = W_NEW;
        @(negedge clk);
        start = 1'b0;
        chk("t2_rdy_cpurst", load_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_rdy_run", load_ready, 0);
            chk("t2_instr", instruction, prog[i]);
        end
        @(negedge clk);
        chk("t2_halt", halted, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t2_idle_rdy", load_ready, 1);
        chk("t2_idle_halt", halted, 0);
        @(negedge clk);
        load_valid = 1'b0;
        go();
        repeat (3) @(negedge clk);
        chk("t2_new_word", instruction, W_NEW);
        @(negedge clk);
        chk("t2_halt2", halted, 1);
        chk("t2_pc", pc_in, 2);
        chk("t2_cnt", cycle_count, 3);

        // cycle budget on JMP 0 loop
        do_clear();
        ld(9'd0, W_J0);
        max_cycles = 16'd10;
        go();
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!running) break;
            n++;
        end
        chk("t3_runs", n, 10);
        chk("t3_halt", halted, 1);
        chk("t3_timeout", timeout, 1);
        chk("t3_cnt", cycle_count, 10);
        chk("t3_errpc", err_pc, 0);
        max_cycles = '0;

        // bad load address, then jump out of range
        do_clear();
        load_valid = 1'b1; load_addr = 9'd300; load_data = W_ADD;
        @(negedge clk);
        load_valid = 1'b0;
        chk("t4_rdy", load_ready, 1);
        chk("t4_errload", err_load, 1);
        ld(9'd0, W_J300);
        go();
        @(negedge clk);
        chk("t4_jmp", instruction, W_J300);
        @(negedge clk);
        chk("t4_pc300", pc_in, 300);
        chk("t4_oob_instr", instruction, W_HLT);
        chk("t4_oob_run", running, 1);
        @(negedge clk);
        chk("t4_halt", halted, 1);
        chk("t4_errpc", err_pc, 1);
        chk("t4_timeout_clr", timeout, 0);
        chk("t4_hinstr", instruction, W_HLT);
        chk("t4_cnt", cycle_count, 2);
        chk("t4_errload_sticky", err_load, 1);

        // stop in 3rd RUN cycle; start during RUN ignored
        do_clear();
        for (int i = 0; i < 10; i++) ld(9'(i), W_NOP);
        go();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_ign_start", {running, pc_in}, {1'b1, 32'd1});
        @(negedge clk);
        chk("t5_pc2", pc_in, 2);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t5_halt", halted, 1);
        chk("t5_pc3", pc_in, 3);
        chk("t5_cnt", cycle_count, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold", pc_in, 3);
        end

        // start+clear together from HALTED, then async reset mid-RUN
        start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        chk("t6_startwins", {running, halted, cpu_reset_n, load_ready}, 0);
        repeat (2) @(negedge clk);
        chk("t6_run", running, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_cpurst", cpu_reset_n, 0);
        chk("t6_async_run", running, 0);
        chk("t6_async_rdy", load_ready, 1);
        chk("t6_async_errload", err_load, 0);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t6_core_pc0", pc_in, 0);
        go();
        @(negedge clk);
        chk("t6_rst_pc", pc_in, 0);
        chk("t6_rst_cnt", cycle_count, 0);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t6_halt", halted, 1);
        chk("t6_cnt", cycle_count, 2);
        chk("t6_pc", pc_in, 2);
        chk("t6_flags", {err_pc, err_load, timeout}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
